// File: rtl/control_sequencer_if.sv
// Control strobes, status and instruction inputs between the control sequencer and the datapath.
// master = sequencer side, slave = datapath side.
interface control_sequencer_if #(
  parameter int unsigned ALU_W = 12
) ();
  logic             run;
  logic [31:0]      ir;
  logic             PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin;
  logic             Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout, RAMwrite;
  logic [ALU_W-1:0] ALUControl;
  logic             busy;
  logic             instr_done;
  logic             illegal;

  modport master (
    input  run, ir,
    output PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin,
    output Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout, RAMwrite,
    output ALUControl, busy, instr_done, illegal
  );

  modport slave (
    output run, ir,
    input  PCout, MARin, IncPC, Zin, PCin, Zlowout, MDRRead, MDRin, MDRout, IRin,
    input  Gra, Grb, Grc, Rin_in, Rout_in, BAout, Yin, Cout, RAMwrite,
    input  ALUControl, busy, instr_done, illegal
  );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute control sequencer. Each step is held for a programmable number
// of cycles; memory steps get extra latency. Strobes are decoded from the registered state.
module control_sequencer #(
  parameter int unsigned STEP_HOLD = 1,
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned ALU_W     = 12
) (
  input logic                 clk,
  input logic                 clr,
  control_sequencer_if.master cs
);

  typedef enum logic [3:0] {
    StIdle, StF0, StF1, StF2, StF3, StE3, StE4, StE5, StE6, StE7
  } state_e;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAdd  = 5'b00011;
  localparam logic [4:0] OpSub  = 5'b00100;
  localparam logic [4:0] OpAnd  = 5'b01001;
  localparam logic [4:0] OpOr   = 5'b01010;
  localparam logic [4:0] OpAddi = 5'b01011;
  localparam logic [4:0] OpAndi = 5'b01100;
  localparam logic [4:0] OpOri  = 5'b01101;

  state_e     state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [4:0] opcode_q, opcode_d;
  logic [4:0] hold_len;
  logic       last;
  logic       is_mem;
  logic [4:0] ir_op;
  logic       ir_legal;
  logic       unused_ir;

  assign ir_op     = cs.ir[31:27];
  assign unused_ir = ^cs.ir[26:0];

  always_comb begin
    ir_legal = 1'b0;
    case (ir_op)
      OpLd, OpLdi, OpSt, OpAdd, OpSub, OpAnd, OpOr, OpAddi, OpAndi, OpOri: ir_legal = 1'b1;
      default: ir_legal = 1'b0;
    endcase
  end

  // Memory steps: fetch read, ld data read, st RAM write.
  assign is_mem   = (state_q == StF2) ||
                    ((state_q == StE6) && (opcode_q == OpLd)) ||
                    ((state_q == StE7) && (opcode_q == OpSt));
  assign hold_len = is_mem ? 5'(STEP_HOLD + MEM_LAT) : 5'(STEP_HOLD);
  assign last     = (cnt_q == hold_len - 5'd1);

  always_comb begin
    logic boundary;
    state_d       = state_q;
    cnt_d         = cnt_q;
    opcode_d      = opcode_q;
    boundary      = 1'b0;
    cs.illegal    = 1'b0;
    if (state_q == StIdle) begin
      cnt_d = 5'd0;
      if (cs.run) state_d = StF0;
    end else if (!last) begin
      cnt_d = cnt_q + 5'd1;
    end else begin
      cnt_d = 5'd0;
      case (state_q)
        StF0: state_d = StF1;
        StF1: state_d = StF2;
        StF2: state_d = StF3;
        StF3: begin
          opcode_d = ir_op;
          if (ir_legal) begin
            state_d = StE3;
          end else begin
            cs.illegal = 1'b1;
            boundary   = 1'b1;
          end
        end
        StE3: state_d = StE4;
        StE4: state_d = StE5;
        StE5: begin
          if ((opcode_q == OpLd) || (opcode_q == OpSt)) state_d = StE6;
          else boundary = 1'b1;
        end
        StE6: state_d = StE7;
        StE7: boundary = 1'b1;
        default: state_d = StIdle;
      endcase
      if (boundary) state_d = cs.run ? StF0 : StIdle;
    end
    cs.instr_done = boundary;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      opcode_q <= 5'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
    end
  end

  logic       op_mem;   // ld/st: address computed as base + constant
  logic       op_imm;   // second operand from the C field
  logic [1:0] alu_idx;

  assign op_mem = (opcode_q == OpLd) || (opcode_q == OpSt);
  assign op_imm = op_mem || (opcode_q == OpLdi) || (opcode_q == OpAddi) ||
                  (opcode_q == OpAndi) || (opcode_q == OpOri);

  always_comb begin
    case (opcode_q)
      OpSub:         alu_idx = 2'd1;
      OpAnd, OpAndi: alu_idx = 2'd2;
      OpOr, OpOri:   alu_idx = 2'd3;
      default:       alu_idx = 2'd0;
    endcase
  end

  always_comb begin
    cs.PCout      = 1'b0;
    cs.MARin      = 1'b0;
    cs.IncPC      = 1'b0;
    cs.Zin        = 1'b0;
    cs.PCin       = 1'b0;
    cs.Zlowout    = 1'b0;
    cs.MDRRead    = 1'b0;
    cs.MDRin      = 1'b0;
    cs.MDRout     = 1'b0;
    cs.IRin       = 1'b0;
    cs.Gra        = 1'b0;
    cs.Grb        = 1'b0;
    cs.Grc        = 1'b0;
    cs.Rin_in     = 1'b0;
    cs.Rout_in    = 1'b0;
    cs.BAout      = 1'b0;
    cs.Yin        = 1'b0;
    cs.Cout       = 1'b0;
    cs.RAMwrite   = 1'b0;
    cs.ALUControl = '0;
    cs.busy       = (state_q != StIdle);
    case (state_q)
      StF0: begin
        cs.PCout = 1'b1;
        cs.MARin = 1'b1;
        cs.IncPC = 1'b1;
        cs.Zin   = 1'b1;
      end
      StF1: begin
        cs.Zlowout = 1'b1;
        cs.PCin    = 1'b1;
      end
      StF2: begin
        cs.MDRRead = 1'b1;
        cs.MDRin   = 1'b1;
      end
      StF3: begin
        cs.MDRout = 1'b1;
        cs.IRin   = 1'b1;
      end
      StE3: begin
        cs.Grb = 1'b1;
        cs.Yin = 1'b1;
        // ldi/ld/st use the base-address path so R0 reads as zero
        if ((opcode_q == OpLdi) || op_mem) cs.BAout = 1'b1;
        else cs.Rout_in = 1'b1;
      end
      StE4: begin
        cs.Zin                 = 1'b1;
        cs.ALUControl[alu_idx] = 1'b1;
        if (op_imm) begin
          cs.Cout = 1'b1;
        end else begin
          cs.Grc     = 1'b1;
          cs.Rout_in = 1'b1;
        end
      end
      StE5: begin
        cs.Zlowout = 1'b1;
        if (op_mem) begin
          cs.MARin = 1'b1;
        end else begin
          cs.Gra    = 1'b1;
          cs.Rin_in = 1'b1;
        end
      end
      StE6: begin
        cs.MDRin = 1'b1;
        if (opcode_q == OpLd) begin
          cs.MDRRead = 1'b1;
        end else begin
          cs.Gra     = 1'b1;
          cs.Rout_in = 1'b1;
        end
      end
      StE7: begin
        if (opcode_q == OpSt) begin
          cs.RAMwrite = 1'b1;
        end else begin
          cs.MDRout = 1'b1;
          cs.Gra    = 1'b1;
          cs.Rin_in = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule
